// File: rtl/xosera_pkg.sv
// Shared pixel and sequencer types for the blend pipeline.
// argb_t carries a 2-bit alpha in [15:14] above 14 bits of colour.
package xosera_pkg;

  typedef struct packed {
    logic [1:0]  alpha;
    logic [13:0] rgb;
  } argb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } blend_seq_state_t;

  localparam logic [1:0] ALPHA_MAX = 2'b11;

endpackage

// File: rtl/video_blend_seq.sv
// Fade sequencer rewriting playfield B alpha; every pixel/sync output is 1 cycle late, commands stall (cmd_ready_o=0) outside IDLE.
// Optional line window built only when VIDEO_BLEND_SEQ_WINDOW_EN is defined.
module video_blend_seq
  import xosera_pkg::*;
#(
  parameter int RATE_W = 4,
  parameter int LINE_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vsync_i,
  input  logic              hsync_i,
  input  logic              dv_de_i,
  input  logic [15:0]       colorA_xrgb_i,
  input  logic [15:0]       colorB_xrgb_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_dir_i,
  input  logic [RATE_W-1:0] cmd_rate_i,
  input  logic [LINE_W-1:0] line_start_i,
  input  logic [LINE_W-1:0] line_end_i,
  input  logic              abort_i,
  input  logic              ovr_clear_i,
  output logic [15:0]       colorA_xrgb_o,
  output logic [15:0]       colorB_xrgb_o,
  output logic              vsync_o,
  output logic              hsync_o,
  output logic              dv_de_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        level_o
);

  blend_seq_state_t  state, state_nx;
  logic [1:0]        level, level_nx;
  logic              ovr_en, ovr_en_nx;
  logic              dir_q, dir_nx;
  logic [RATE_W-1:0] rate_q, rate_nx;
  logic [RATE_W-1:0] fcnt, fcnt_nx;
  logic              frame_edge;
  logic              accept;
  logic              in_window;
  argb_t             b_in, b_mod;

  // vsync_o/hsync_o double as the registered copies for edge detection
  assign frame_edge  = vsync_i & ~vsync_o;
  assign accept      = (state == IDLE) & cmd_valid_i;
  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign level_o     = level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      level  <= 2'd0;
      ovr_en <= 1'b0;
      dir_q  <= 1'b0;
      rate_q <= '0;
      fcnt   <= '0;
    end else begin
      state  <= state_nx;
      level  <= level_nx;
      ovr_en <= ovr_en_nx;
      dir_q  <= dir_nx;
      rate_q <= rate_nx;
      fcnt   <= fcnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    level_nx  = level;
    ovr_en_nx = ovr_en;
    dir_nx    = dir_q;
    rate_nx   = rate_q;
    fcnt_nx   = fcnt;
    if (ovr_clear_i) ovr_en_nx = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid_i) begin
          dir_nx    = cmd_dir_i;
          rate_nx   = cmd_rate_i;
          level_nx  = cmd_dir_i ? 2'd0 : ALPHA_MAX;
          ovr_en_nx = 1'b1;
          state_nx  = ARM;
        end
      end
      ARM: begin
        if (abort_i) begin
          state_nx = IDLE;
        end else if (frame_edge) begin
          fcnt_nx  = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_nx = IDLE;
        end else if (frame_edge) begin
          if (fcnt == rate_q) begin
            fcnt_nx  = '0;
            level_nx = dir_q ? level + 2'd1 : level - 2'd1;
            if (level_nx == (dir_q ? ALPHA_MAX : 2'd0)) state_nx = DONE;
          end else begin
            fcnt_nx = fcnt + 1'b1;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef VIDEO_BLEND_SEQ_WINDOW_EN
  logic [LINE_W-1:0] line_cnt, start_q, end_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt <= '0;
      start_q  <= '0;
      end_q    <= '0;
    end else begin
      if (accept) begin
        start_q <= line_start_i;
        end_q   <= line_end_i;
      end
      if (frame_edge) begin
        line_cnt <= '0;
      end else if (hsync_i & ~hsync_o & ~(&line_cnt)) begin
        line_cnt <= line_cnt + 1'b1;
      end
    end
  end

  // start >= end naturally yields an empty window
  assign in_window = (line_cnt >= start_q) && (line_cnt < end_q);
`else
  logic unused_window;
  assign unused_window = ^{line_start_i, line_end_i};
  assign in_window     = 1'b1;
`endif

  always_comb begin
    b_in  = argb_t'(colorB_xrgb_i);
    b_mod = b_in;
    if (ovr_en && in_window) b_mod.alpha = level;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      colorA_xrgb_o <= 16'h0000;
      colorB_xrgb_o <= 16'h0000;
      vsync_o       <= 1'b0;
      hsync_o       <= 1'b0;
      dv_de_o       <= 1'b0;
    end else begin
      colorA_xrgb_o <= colorA_xrgb_i;
      colorB_xrgb_o <= b_mod;
      vsync_o       <= vsync_i;
      hsync_o       <= hsync_i;
      dv_de_o       <= dv_de_i;
    end
  end

endmodule

// File: tb/tb_video_blend_seq.sv
// Randomised self-checking bench for video_blend_seq against a frame-level fade model.
module tb_video_blend_seq;
  import xosera_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vsync_i = 1'b0, hsync_i = 1'b0, dv_de_i = 1'b0;
  logic [15:0] colorA_xrgb_i = '0, colorB_xrgb_i = '0;
  logic        cmd_valid_i = 1'b0, cmd_dir_i = 1'b0;
  logic [3:0]  cmd_rate_i = '0;
  logic [10:0] line_start_i = '0, line_end_i = '0;
  logic        abort_i = 1'b0, ovr_clear_i = 1'b0;
  logic        cmd_ready_o, busy_o, done_o;
  logic [15:0] colorA_xrgb_o, colorB_xrgb_o;
  logic        vsync_o, hsync_o, dv_de_o;
  logic [1:0]  level_o;

  video_blend_seq #(.RATE_W(4), .LINE_W(11)) dut (
    .clk(clk), .reset_n(reset_n),
    .vsync_i(vsync_i), .hsync_i(hsync_i), .dv_de_i(dv_de_i),
    .colorA_xrgb_i(colorA_xrgb_i), .colorB_xrgb_i(colorB_xrgb_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_dir_i(cmd_dir_i), .cmd_rate_i(cmd_rate_i),
    .line_start_i(line_start_i), .line_end_i(line_end_i),
    .abort_i(abort_i), .ovr_clear_i(ovr_clear_i),
    .colorA_xrgb_o(colorA_xrgb_o), .colorB_xrgb_o(colorB_xrgb_o),
    .vsync_o(vsync_o), .hsync_o(hsync_o), .dv_de_o(dv_de_o),
    .busy_o(busy_o), .done_o(done_o), .level_o(level_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int done_seen = 0;
  logic [1:0] m_level = 2'd0;
  bit   m_ovr = 1'b0;
  int   m_line = 0, m_ls = 0, m_le = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (done_o) done_seen++;
  endtask

  task automatic pix_check(input int n, input string tag);
    logic [15:0] a, b, bexp;
    logic de;
    bit win;
    vsync_i = 1'b0;
    hsync_i = 1'b0;
`ifdef VIDEO_BLEND_SEQ_WINDOW_EN
    win = (m_line >= m_ls) && (m_line < m_le);
`else
    win = 1'b1;
`endif
    for (int i = 0; i < n; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      de = 1'($urandom);
      colorA_xrgb_i = a;
      colorB_xrgb_i = b;
      dv_de_i = de;
      tick();
      bexp = b;
      if (m_ovr && win) bexp[15:14] = m_level;
      chk({tag, "_a"}, colorA_xrgb_o, a);
      chk({tag, "_b"}, colorB_xrgb_o, bexp);
      chk({tag, "_de"}, dv_de_o, de);
    end
  endtask

  task automatic frame;
    colorA_xrgb_i = 16'($urandom);
    colorB_xrgb_i = 16'($urandom);
    vsync_i = 1'b1;
    tick();
    chk("vsync_o_hi", vsync_o, 1'b1);
    tick();
    vsync_i = 1'b0;
    tick();
    tick();
    m_line = 0;
  endtask

  task automatic hs_pulse;
    hsync_i = 1'b1;
    tick();
    chk("hsync_o_hi", hsync_o, 1'b1);
    hsync_i = 1'b0;
    tick();
    if (m_line < 2047) m_line++;
  endtask

  task automatic send_cmd(input logic dir, input int rate, input int ls, input int le, input bit clr);
    cmd_dir_i    = dir;
    cmd_rate_i   = 4'(rate);
    line_start_i = 11'(ls);
    line_end_i   = 11'(le);
    chk("cmd_ready_idle", cmd_ready_o, 1'b1);
    cmd_valid_i = 1'b1;
    ovr_clear_i = clr;
    tick();
    cmd_valid_i = 1'b0;
    ovr_clear_i = 1'b0;
    chk("busy_after_cmd", busy_o, 1'b1);
    m_level = dir ? 2'd0 : 2'd3;
    m_ovr = 1'b1;
    m_ls = ls;
    m_le = le;
    chk("start_level", level_o, m_level);
  endtask

  task automatic run_fade(input logic dir, input int rate, input int ls, input int le, input bit poke);
    int total;
    total = 3 * (rate + 1);
    send_cmd(dir, rate, ls, le, 1'b0);
    done_seen = 0;
    frame();
    chk("arm_level", level_o, m_level);
    chk("arm_busy", busy_o, 1'b1);
    for (int k = 1; k <= total; k++) begin
      if (poke && k == 2) begin
        cmd_valid_i = 1'b1;
        cmd_dir_i   = ~dir;
        cmd_rate_i  = 4'd0;
        #1;
        chk("ready_in_run", cmd_ready_o, 1'b0);
        tick();
        cmd_valid_i = 1'b0;
      end
      frame();
      m_level = dir ? 2'(k / (rate + 1)) : 2'(3 - k / (rate + 1));
      chk("fade_level", level_o, m_level);
      if (k < total) begin
        chk("fade_busy", busy_o, 1'b1);
        chk("fade_no_done", done_seen, 0);
      end
    end
    chk("done_once", done_seen, 1);
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_ready", cmd_ready_o, 1'b1);
    pix_check(3, "fade_pix");
  endtask

  initial begin
    colorA_xrgb_i = 16'hffff;
    colorB_xrgb_i = 16'hffff;
    vsync_i = 1'b1;
    hsync_i = 1'b1;
    dv_de_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_level", level_o, 2'd0);
    chk("rst_colA", colorA_xrgb_o, 16'h0);
    chk("rst_colB", colorB_xrgb_o, 16'h0);
    chk("rst_sync", {vsync_o, hsync_o, dv_de_o}, 3'b000);
    vsync_i = 1'b0;
    hsync_i = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    m_line = 0;

    pix_check(4, "pass_idle");
    run_fade(1'b1, 0, 0, 2047, 1'b0);
    run_fade(1'b0, 2, 0, 2047, 1'b1);
    run_fade(1'b1, int'($urandom_range(0, 3)), 0, 2047, 1'b0);

    ovr_clear_i = 1'b1;
    tick();
    ovr_clear_i = 1'b0;
    m_ovr = 1'b0;
    pix_check(4, "ovr_clear");

    send_cmd(1'b0, 1, 0, 2047, 1'b1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("clr_accept_idle", busy_o, 1'b0);
    pix_check(3, "clr_accept_pix");

    send_cmd(1'b1, 0, 0, 2047, 1'b0);
    done_seen = 0;
    frame();
    frame();
    m_level = 2'd1;
    chk("abort_pre_level", level_o, m_level);
    vsync_i = 1'b1;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_ready", cmd_ready_o, 1'b1);
    chk("abort_level", level_o, m_level);
    cmd_valid_i = 1'b1;
    cmd_dir_i = 1'b0;
    tick();
    cmd_valid_i = 1'b0;
    chk("abort_no_done", done_seen, 0);
    chk("abort_reaccept", busy_o, 1'b1);
    chk("reaccept_level", level_o, 2'd3);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    vsync_i = 1'b0;
    m_level = 2'd3;
    m_line = 0;
    chk("abort_arm_idle", busy_o, 1'b0);

`ifdef VIDEO_BLEND_SEQ_WINDOW_EN
    run_fade(1'b1, 0, 10, 20, 1'b0);
    for (int ln = 1; ln <= 21; ln++) begin
      hs_pulse();
      if (ln == 9 || ln == 10 || ln == 19 || ln == 20 || ln == 21) pix_check(2, "win_10_20");
    end
    run_fade(1'b1, 0, 20, 10, 1'b0);
    for (int ln = 1; ln <= 15; ln++) begin
      hs_pulse();
      if (ln % 5 == 0) pix_check(2, "win_empty");
    end
`else
    run_fade(1'b1, 0, 20, 10, 1'b0);
    for (int ln = 1; ln <= 12; ln++) begin
      hs_pulse();
      if (ln % 4 == 0) pix_check(2, "win_ignored");
    end
`endif

    send_cmd(1'b0, 1, 0, 2047, 1'b0);
    frame();
    frame();
    colorA_xrgb_i = 16'hffff;
    colorB_xrgb_i = 16'hffff;
    dv_de_i = 1'b1;
    vsync_i = 1'b1;
    tick();
    chk("pre_rst_busy", busy_o, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_level", level_o, 2'd0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_ready", cmd_ready_o, 1'b1);
    chk("mid_rst_colA", colorA_xrgb_o, 16'h0);
    chk("mid_rst_colB", colorB_xrgb_o, 16'h0);
    chk("mid_rst_sync", {vsync_o, dv_de_o}, 2'b00);
    vsync_i = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", cmd_ready_o, 1'b1);
    chk("post_rst_level", level_o, 2'd0);
    m_level = 2'd0;
    m_ovr = 1'b0;
    m_line = 0;
    pix_check(3, "post_rst_pix");
    run_fade(1'b1, 0, 0, 2047, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
